// File: rtl/tx_sched_if.sv
// tx_sched_if: requester/engine signal bundle for tx_sched.
// master = scheduler side, slave = requesters plus transmit engine.
interface tx_sched_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       ack0;
  logic       ack1;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       busy;
  logic       grant_id;
`ifdef TX_SCHED_TIMEOUT_EN
  logic       tx_timeout;
`endif

  modport master (
    input  req0, req1, data0, data1, tx_rdy,
    output ack0, ack1, tx_start, tx_data, busy, grant_id
`ifdef TX_SCHED_TIMEOUT_EN
    , output tx_timeout
`endif
  );

  modport slave (
    output req0, req1, data0, data1, tx_rdy,
    input  ack0, ack1, tx_start, tx_data, busy, grant_id
`ifdef TX_SCHED_TIMEOUT_EN
    , input tx_timeout
`endif
  );
endinterface

// File: rtl/tx_sched.sv
// tx_sched: round-robin scheduler, two byte requesters -> one tx engine.
// Ports: Clk; Rst (async, active-low); bus (tx_sched_if.master):
//   req0/req1, data0/data1 in; ack0/ack1 pulses; tx_start, tx_data out;
//   tx_rdy in; busy, grant_id out.
// Macro TX_SCHED_TIMEOUT_EN adds a BUSY watchdog (TIMEOUT_CYC cycles)
//   and bus.tx_timeout, which pulses in the cycle the FSM re-enters IDLE.
module tx_sched #(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       Clk,
  input  logic       Rst,
  tx_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, HOLD, BUSY} state_t;

  state_t     state_q;
  logic [7:0] tx_data_q;
  logic       tx_start_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       busy_q;
  logic       grant_q;
  logic       last_q;
  logic       free_q;
  logic       win;

`ifdef TX_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;
  logic          tmo_q;
`else
  // Without the watchdog the limit has no effect.
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
`endif

  // Contention goes to whoever was not served last.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) win = ~last_q;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      free_q     <= 1'b1;
`ifdef TX_SCHED_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
      tmo_q      <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.tx_rdy) free_q <= 1'b1;
          // START outputs are loaded here so they are live in START.
          if ((bus.req0 || bus.req1) && free_q) begin
            state_q    <= START;
            tx_data_q  <= win ? bus.data1 : bus.data0;
            tx_start_q <= 1'b1;
            ack0_q     <= ~win;
            ack1_q     <= win;
            grant_q    <= win;
            last_q     <= win;
            free_q     <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: state_q <= HOLD;
        // Engine drops tx_rdy one cycle late; ignore it here.
        HOLD: begin
          state_q <= BUSY;
`ifdef TX_SCHED_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        BUSY: begin
          if (bus.tx_rdy) begin
            state_q <= IDLE;
            free_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
`ifdef TX_SCHED_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_q <= IDLE;
            free_q  <= 1'b1;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
`ifdef TX_SCHED_TIMEOUT_EN
  assign bus.tx_timeout = tmo_q;
`endif

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: randomized self-checking bench for tx_sched.
// Reference: round-robin rule and transfer timing kept as plain variables.
module tb_tx_sched;

  logic Clk = 1'b0;
  logic Rst;
  tx_sched_if bus();

  tx_sched #(.TIMEOUT_CYC(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit last_g;  // model: requester served most recently

  task automatic test_reset();
    Rst = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    bus.data0 = 0; bus.data1 = 0;
    bus.tx_rdy = 0;
    repeat (3) @(negedge Clk);
    n_chk++;
    if (bus.tx_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_tx_start got=%b exp=0", bus.tx_start);
    end
    n_chk++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      n_fail++; $display("FAIL rst_acks got=%b exp=00", {bus.ack0, bus.ack1});
    end
    n_chk++;
    if (bus.tx_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data);
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy got=%b exp=0", bus.busy);
    end
    n_chk++;
    if (bus.grant_id !== 1'b0) begin
      n_fail++; $display("FAIL rst_grant got=%b exp=0", bus.grant_id);
    end
    Rst = 1'b1;
    last_g = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_single();
    bus.data0 = 8'hA5;
    bus.req0  = 1;
    @(negedge Clk);
    n_chk++;
    if ({bus.tx_start, bus.ack0, bus.ack1, bus.grant_id, bus.busy,
         bus.tx_data} !== {5'b11001, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_start got=%b_%h exp=11001_a5",
               {bus.tx_start, bus.ack0, bus.ack1, bus.grant_id, bus.busy},
               bus.tx_data);
    end
    bus.req0 = 0;
    last_g = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      n_chk++;
      if ({bus.busy, bus.tx_start, bus.ack0} !== 3'b100) begin
        n_fail++;
        $display("FAIL single_busy[%0d] got=%b exp=100", i,
                 {bus.busy, bus.tx_start, bus.ack0});
      end
    end
    bus.tx_rdy = 1;
    @(negedge Clk);
    bus.tx_rdy = 0;
    n_chk++;
    if ({bus.busy, bus.tx_data} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_done got=%b_%h exp=0_a5", bus.busy, bus.tx_data);
    end
  endtask

  task automatic test_hold_mask();
    logic [7:0] d;
    d = 8'($urandom);
    bus.data1  = d;
    bus.req1   = 1;
    bus.tx_rdy = 1;
    @(negedge Clk);
    n_chk++;
    if ({bus.tx_start, bus.ack1, bus.tx_data} !== {2'b11, d}) begin
      n_fail++;
      $display("FAIL hold_start got=%b%b_%h exp=11_%h",
               bus.tx_start, bus.ack1, bus.tx_data, d);
    end
    bus.req1 = 0;
    last_g = 1'b1;
    @(negedge Clk);
    bus.tx_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      n_chk++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL hold_busy[%0d] got=%b exp=1", i, bus.busy);
      end
    end
    bus.tx_rdy = 1;
    @(negedge Clk);
    bus.tx_rdy = 0;
    n_chk++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_done got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_withdrawn();
    bus.data0 = 8'($urandom);
    bus.req0  = 1;
    @(negedge Clk);
    bus.req0 = 0;
    last_g = 1'b0;
    repeat (2) @(negedge Clk);
    bus.data1 = 8'($urandom);
    bus.req1  = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      bus.req1 = 0;
      n_chk++;
      if ({bus.tx_start, bus.ack0, bus.ack1, bus.busy} !== 4'b0001) begin
        n_fail++;
        $display("FAIL wdrawn_busy[%0d] got=%b exp=0001", i,
                 {bus.tx_start, bus.ack0, bus.ack1, bus.busy});
      end
    end
    bus.tx_rdy = 1;
    @(negedge Clk);
    bus.tx_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      n_chk++;
      if ({bus.tx_start, bus.ack1, bus.busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL wdrawn_idle[%0d] got=%b exp=000", i,
                 {bus.tx_start, bus.ack1, bus.busy});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    bus.data0 = 8'($urandom);
    bus.req0  = 1;
    @(negedge Clk);
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.tx_start, bus.ack0, bus.ack1, bus.busy, bus.grant_id,
         bus.tx_data} !== 13'h0) begin
      n_fail++;
      $display("FAIL rstmid_async got=%b_%h exp=00000_00",
               {bus.tx_start, bus.ack0, bus.ack1, bus.busy, bus.grant_id},
               bus.tx_data);
    end
    repeat (2) begin
      @(negedge Clk);
      n_chk++;
      if ({bus.tx_start, bus.ack0, bus.busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rstmid_hold got=%b exp=000",
                 {bus.tx_start, bus.ack0, bus.busy});
      end
    end
    bus.req0 = 0;
    Rst = 1'b1;
    last_g = 1'b1;
    @(negedge Clk);
    d = 8'($urandom);
    bus.data1 = d;
    bus.req1  = 1;
    @(negedge Clk);
    n_chk++;
    if ({bus.tx_start, bus.ack0, bus.ack1, bus.grant_id, bus.tx_data}
        !== {4'b1011, d}) begin
      n_fail++;
      $display("FAIL rstmid_req1 got=%b_%h exp=1011_%h",
               {bus.tx_start, bus.ack0, bus.ack1, bus.grant_id},
               bus.tx_data, d);
    end
    bus.req1 = 0;
    last_g = 1'b1;
    repeat (2) @(negedge Clk);
    bus.tx_rdy = 1;
    @(negedge Clk);
    bus.tx_rdy = 0;
  endtask

  // First four rounds: both held high (11/22); then random patterns.
  task automatic test_contention();
    bit         r0, r1, exp;
    logic [7:0] d0, d1, ed;
    int         k;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin
        r0 = 1; r1 = 1; d0 = 8'h11; d1 = 8'h22;
      end else begin
        k  = $urandom_range(1, 3);
        r0 = k[0]; r1 = k[1];
        d0 = 8'($urandom); d1 = 8'($urandom);
      end
      exp = (r0 && r1) ? ~last_g : r1;
      ed  = exp ? d1 : d0;
      bus.req0 = r0; bus.req1 = r1;
      bus.data0 = d0; bus.data1 = d1;
      @(negedge Clk);
      n_chk++;
      if ({bus.tx_start, bus.ack0, bus.ack1, bus.grant_id, bus.tx_data}
          !== {1'b1, ~exp, exp, exp, ed}) begin
        n_fail++;
        $display("FAIL rr[%0d] got=%b_%h exp=%b_%h", i,
                 {bus.tx_start, bus.ack0, bus.ack1, bus.grant_id},
                 bus.tx_data, {1'b1, ~exp, exp, exp}, ed);
      end
      last_g = exp;
      if (i >= 3) begin
        bus.req0 = 0; bus.req1 = 0;
      end
      k = $urandom_range(2, 6);
      repeat (k) begin
        @(negedge Clk);
        n_chk++;
        if ({bus.tx_start, bus.ack0, bus.ack1, bus.busy} !== 4'b0001) begin
          n_fail++;
          $display("FAIL rr_wait[%0d] got=%b exp=0001", i,
                   {bus.tx_start, bus.ack0, bus.ack1, bus.busy});
        end
      end
      bus.tx_rdy = 1;
      @(negedge Clk);
      bus.tx_rdy = 0;
      n_chk++;
      if ({bus.busy, bus.tx_start} !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_idle[%0d] got=%b exp=00", i,
                 {bus.busy, bus.tx_start});
      end
    end
  endtask

`ifdef TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [7:0] d;
    bus.data0 = 8'($urandom);
    bus.req0  = 1;
    @(negedge Clk);
    bus.req0 = 0;
    last_g = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge Clk);
      n_chk++;
      if ({bus.tx_timeout, bus.busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL tmo_wait[%0d] got=%b exp=01", i,
                 {bus.tx_timeout, bus.busy});
      end
    end
    @(negedge Clk);
    n_chk++;
    if ({bus.tx_timeout, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmo_pulse got=%b exp=10", {bus.tx_timeout, bus.busy});
    end
    @(negedge Clk);
    n_chk++;
    if (bus.tx_timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_once got=%b exp=0", bus.tx_timeout);
    end
    d = 8'($urandom);
    bus.data1 = d;
    bus.req1  = 1;
    @(negedge Clk);
    n_chk++;
    if ({bus.tx_start, bus.ack1, bus.tx_data} !== {2'b11, d}) begin
      n_fail++;
      $display("FAIL tmo_next got=%b%b_%h exp=11_%h",
               bus.tx_start, bus.ack1, bus.tx_data, d);
    end
    bus.req1 = 0;
    last_g = 1'b1;
    repeat (2) @(negedge Clk);
    bus.tx_rdy = 1;
    @(negedge Clk);
    bus.tx_rdy = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold_mask();
    test_withdrawn();
    test_reset_mid();
    test_contention();
`ifdef TX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 The parameter TIMEOUT_CYC SHALL default to 200000 and SHALL give the maximum Clk cycles spent in BUSY before watchdog abort.
REQ-002 Clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  reset; it SHALL be asynchronous and active-low.
REQ-004 req0, req1  input  1 each  level transfer requests from requester 0 and requester 1.
REQ-005 data0, data1  input  8 each  byte offered by each requester; each SHALL be held stable while its req is high.
REQ-006 ack0, ack1  output  1 each  one-cycle pulse when the byte of the matching requester is accepted.
REQ-007 tx_start  output  1  one-cycle start pulse to the transmit engine.
REQ-008 tx_data  output  8  byte to the transmit engine; it SHALL be valid while tx_start is high.
REQ-009 tx_rdy  input  1  engine ready; it SHALL be sampled synchronously.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 grant_id  output  1  identity of the requester most recently served.

Function
REQ-012 The FSM SHALL have four states: IDLE, START, HOLD and BUSY; the encoding is free.
REQ-013 IDLE: when (req0|req1) and eng_free, the FSM SHALL go to START and latch the winner's data into tx_data; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: if both requests are high, the requester not equal to last_grant SHALL win; if one request is high, that requester SHALL win.
REQ-015 START: tx_start=1 and the winner's ack SHALL equal 1 for exactly one cycle, last_grant and grant_id SHALL update to the winner, eng_free SHALL clear, and the FSM SHALL go to HOLD.
REQ-016 HOLD: a single cycle in which tx_rdy is ignored, to cover the engine's one-cycle ready-clear latency; the FSM SHALL go to BUSY unconditionally.
REQ-017 BUSY: when tx_rdy=1 is sampled, eng_free SHALL set and the FSM SHALL go to IDLE; otherwise it SHALL stay in BUSY.
REQ-018 eng_free SHALL reset to 1 so that the first transfer after reset needs no tx_rdy.
REQ-019 In IDLE, eng_free SHALL also set whenever tx_rdy=1 is sampled.
REQ-020 Minimum request-to-tx_start latency SHALL be 2 cycles: the request is sampled in IDLE and tx_start is high in START.
REQ-021 Back-to-back service SHALL occur with no idle cycle beyond a single IDLE cycle between BUSY and START.
REQ-022 A request dropped before ack SHALL be treated as withdrawn, with no ack and no transfer.
REQ-023 A request that stays high after its ack SHALL be treated as a new request for the next byte.
REQ-024 ack0 and ack1 SHALL never be high in the same cycle.
REQ-025 tx_start SHALL never be high outside START.
REQ-026 tx_data SHALL hold its value between transfers.

Reset
REQ-027 While Rst=0 the block SHALL hold these values: state=IDLE, tx_start=0, ack0=0, ack1=0, tx_data=8'h00, busy=0, grant_id=0, last_grant=1, eng_free=1, timeout counter=0.
REQ-028 Reset asserted mid-transfer SHALL abort immediately with no ack and no tx_start.
REQ-029 After reset release, the first request SHALL start normally; if both requests are high, requester 0 SHALL win.

Configuration
REQ-030 With macro TX_SCHED_TIMEOUT_EN defined, a timeout counter SHALL count cycles in BUSY.
REQ-031 With TX_SCHED_TIMEOUT_EN defined, a 1-bit output tx_timeout SHALL pulse for one cycle if TIMEOUT_CYC cycles pass in BUSY without tx_rdy; the FSM SHALL then go to IDLE with eng_free=1.
REQ-032 With TX_SCHED_TIMEOUT_EN defined, the counter SHALL clear on entry to BUSY.
REQ-033 Without TX_SCHED_TIMEOUT_EN, the tx_timeout port and the counter SHALL not exist, and BUSY SHALL wait for tx_rdy indefinitely.

Verification
REQ-034 Single request: after reset, req0=1 with data0=8'hA5 -> tx_start and ack0 high in the same cycle 2 cycles later, tx_data=8'hA5, busy=1 until tx_rdy=1 is sampled.
REQ-035 Contention: req0 and req1 both held high with data 8'h11 and 8'h22 -> order of service 0,1,0,1; each tx_start only after tx_rdy returns; acks alternate.
REQ-036 HOLD masking: tx_rdy held at 1 through the start cycle and the following cycle, then 0 -> FSM does not leave BUSY early.
REQ-037 Withdrawn request: req1 pulsed for 1 cycle while the FSM is in BUSY -> no ack1 and no extra tx_start.
REQ-038 Reset mid-transfer: Rst=0 during BUSY -> all outputs return to reset values immediately; a later req1 alone is served.
REQ-039 Watchdog with TX_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: tx_rdy stuck at 0 -> tx_timeout pulses on BUSY cycle 16, then IDLE, then the next request is served.
